// File: rtl/instruction_aligner_pkg.sv
// rtl/instruction_aligner_pkg.sv - shared fetch widths, length marker and decode helper
package instruction_aligner_pkg;

   localparam int HALF_W  = 16;
   localparam int INSTR_W = 32;

   // Low two bits of a 32-bit instruction's first halfword
   localparam logic [1:0] UNCOMP_MARK = 2'b11;

   // Number of buffered halfwords, 0..3
   typedef logic [1:0] bufCount_t;

   function automatic logic isCompressed(input logic [HALF_W-1:0] hw);
      return hw[1:0] != UNCOMP_MARK;
   endfunction

endpackage

// File: rtl/instruction_aligner_halfword_queue.sv
// rtl/instruction_aligner_halfword_queue.sv - 3-entry halfword shift buffer with pop-then-push
module instruction_aligner_halfword_queue
   import instruction_aligner_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              flush_i,
   input  logic [1:0]        pop_i,
   input  logic [1:0]        push_i,
   input  logic [HALF_W-1:0] push_lo_i,
   input  logic [HALF_W-1:0] push_hi_i,
   output logic [HALF_W-1:0] head0_o,
   output logic [HALF_W-1:0] head1_o,
   output bufCount_t         count_o
);

   logic [HALF_W-1:0] hw_q [3];
   logic [HALF_W-1:0] hw_d [3];
   logic [HALF_W-1:0] shf  [3];
   bufCount_t         count_q;
   bufCount_t         count_d;
   bufCount_t         kept;

   // Pop from the head first, then append new halfwords after the survivors
   always_comb begin
      shf     = hw_q;
      hw_d    = hw_q;
      kept    = count_q - pop_i;
      count_d = count_q;
      case (pop_i)
         2'd1:    shf = '{hw_q[1], hw_q[2], hw_q[2]};
         2'd2:    shf = '{hw_q[2], hw_q[2], hw_q[2]};
         default: shf = hw_q;
      endcase
      for (int i = 0; i < 3; i++) begin
         hw_d[i] = shf[i];
         if (push_i != 2'd0 && bufCount_t'(i) == kept) begin
            hw_d[i] = push_lo_i;
         end
         if (push_i == 2'd2 && bufCount_t'(i) == kept + 2'd1) begin
            hw_d[i] = push_hi_i;
         end
      end
      count_d = kept + push_i;
      if (flush_i) begin
         count_d = '0;
      end
   end

   // Buffer and occupancy registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hw_q    <= '{default: '0};
         count_q <= '0;
      end else begin
         hw_q    <= hw_d;
         count_q <= count_d;
      end
   end

   assign head0_o = hw_q[0];
   assign head1_o = hw_q[1];
   assign count_o = count_q;

endmodule

// File: rtl/instruction_aligner.sv
// rtl/instruction_aligner.sv - turns aligned fetch words into aligned 16/32-bit instructions
module instruction_aligner
   import instruction_aligner_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   output logic [31:0]        fetchAddr,
   input  logic               fetchValid,
   input  logic [31:0]        fetchWord,
   output logic               fetchReady,
   input  logic               redirectValid,
   input  logic [31:0]        redirectPc,
   output logic               instrValid,
   input  logic               instrReady,
   output logic [INSTR_W-1:0] instrWord,
   output logic [31:0]        instrPc,
   output logic               instrIsCompressed
);

   logic [31:0]       headPc_q, headPc_d;
   logic [31:0]       fetchAddr_q, fetchAddr_d;
   logic              skipLow_q, skipLow_d;

   logic [HALF_W-1:0] head0, head1;
   bufCount_t         count;
   logic              head_c;
   logic              accept, consume;
   logic [1:0]        pop_n, push_n;
   logic [HALF_W-1:0] push_lo;

   instruction_aligner_halfword_queue u_queue (
      .clk       (clk),
      .reset     (reset),
      .flush_i   (redirectValid),
      .pop_i     (pop_n),
      .push_i    (push_n),
      .push_lo_i (push_lo),
      .push_hi_i (fetchWord[31:16]),
      .head0_o   (head0),
      .head1_o   (head1),
      .count_o   (count)
   );

   assign head_c = isCompressed(head0);

   // A lone low half of a 32-bit instruction is not presentable
   assign instrValid        = !redirectValid &&
                              (count >= 2'd2 || (count == 2'd1 && head_c));
   assign fetchReady        = !redirectValid && count <= 2'd1;
   assign instrIsCompressed = (count != 2'd0) && head_c;
   assign instrWord         = (count == 2'd0) ? '0 :
                              head_c ? {16'h0000, head0} : {head1, head0};
   assign instrPc           = headPc_q;
   assign fetchAddr         = fetchAddr_q;

   assign accept  = fetchValid && fetchReady;
   assign consume = instrValid && instrReady;
   assign pop_n   = consume ? (head_c ? 2'd1 : 2'd2) : 2'd0;
   assign push_n  = accept ? (skipLow_q ? 2'd1 : 2'd2) : 2'd0;

   // After a redirect into the upper half of a word, the low half is dropped
   assign push_lo = skipLow_q ? fetchWord[31:16] : fetchWord[15:0];

   // Next PC, fetch address and skip flag; redirect overrides any handshake
   always_comb begin
      headPc_d    = headPc_q;
      fetchAddr_d = fetchAddr_q;
      skipLow_d   = skipLow_q;
      if (redirectValid) begin
         headPc_d    = {redirectPc[31:1], 1'b0};
         fetchAddr_d = {redirectPc[31:2], 2'b00};
         skipLow_d   = redirectPc[1];
      end else begin
         if (consume) begin
            headPc_d = headPc_q + (head_c ? 32'd2 : 32'd4);
         end
         if (accept) begin
            fetchAddr_d = fetchAddr_q + 32'd4;
            skipLow_d   = 1'b0;
         end
      end
   end

   // PC and fetch-address registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         headPc_q    <= {RESET_PC[31:1], 1'b0};
         fetchAddr_q <= {RESET_PC[31:2], 2'b00};
         skipLow_q   <= RESET_PC[1];
      end else begin
         headPc_q    <= headPc_d;
         fetchAddr_q <= fetchAddr_d;
         skipLow_q   <= skipLow_d;
      end
   end

endmodule

// File: tb/tb_instruction_aligner.sv
// tb/tb_instruction_aligner.sv - randomized scoreboard bench for instruction_aligner
module tb_instruction_aligner;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] fetchAddr;
   logic        fetchValid;
   logic [31:0] fetchWord;
   logic        fetchReady;
   logic        redirectValid;
   logic [31:0] redirectPc;
   logic        instrValid;
   logic        instrReady;
   logic [31:0] instrWord;
   logic [31:0] instrPc;
   logic        instrIsCompressed;

   instruction_aligner #(.RESET_PC(RESET_PC)) dut (
      .clk               (clk),
      .reset             (reset),
      .fetchAddr         (fetchAddr),
      .fetchValid        (fetchValid),
      .fetchWord         (fetchWord),
      .fetchReady        (fetchReady),
      .redirectValid     (redirectValid),
      .redirectPc        (redirectPc),
      .instrValid        (instrValid),
      .instrReady        (instrReady),
      .instrWord         (instrWord),
      .instrPc           (instrPc),
      .instrIsCompressed (instrIsCompressed)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] w;
      logic [31:0] pc;
      logic        c;
   } exp_t;

   logic [31:0] mem [64];
   exp_t        exp_q [$];
   logic [15:0] hwq [$];
   int          pend;
   logic [31:0] m_fa, m_nxt, m_pc;
   int          n_cmp = 0;
   int          n_err = 0;
   bit          chk_en = 1'b0;
   bit          prev_hold = 1'b0;
   logic [31:0] prev_word, prev_pc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic logic [31:0] memw(input logic [31:0] a);
      return mem[a[7:2]];
   endfunction

   // Model restart: nothing buffered, stream begins at the (even) target pc
   task automatic m_restart(input logic [31:0] pc);
      exp_q.delete();
      hwq.delete();
      pend  = 0;
      m_pc  = pc & 32'hFFFF_FFFE;
      m_nxt = m_pc;
      m_fa  = pc & 32'hFFFF_FFFC;
   endtask

   // A word fetched from m_fa contributes every halfword at or after the next wanted address
   task automatic m_accept(input logic [31:0] w);
      logic [31:0] a;
      logic [15:0] h, dummy;
      for (int k = 0; k < 2; k++) begin
         a = m_fa + 32'(2 * k);
         if (a == m_nxt) begin
            hwq.push_back(k == 0 ? w[15:0] : w[31:16]);
            m_nxt = m_nxt + 32'd2;
            pend++;
         end
      end
      m_fa = m_fa + 32'd4;
      while (hwq.size() > 0) begin
         h = hwq[0];
         if (h[1:0] != 2'b11) begin
            exp_q.push_back('{{16'h0000, h}, m_pc, 1'b1});
            dummy = hwq.pop_front();
            m_pc  = m_pc + 32'd2;
         end else if (hwq.size() >= 2) begin
            exp_q.push_back('{{hwq[1], h}, m_pc, 1'b0});
            dummy = hwq.pop_front();
            dummy = hwq.pop_front();
            m_pc  = m_pc + 32'd4;
         end else begin
            break;
         end
      end
   endtask

   task automatic step(input bit fv, input bit rdy, input bit rv, input logic [31:0] rpc);
      @(negedge clk);
      fetchValid    = fv;
      instrReady    = rdy;
      redirectValid = rv;
      redirectPc    = rpc;
      fetchWord     = fv ? memw(fetchAddr) : $urandom;
      #2;
      if (rv) m_restart(rpc);
      else if (fv && fetchReady) m_accept(fetchWord);
   endtask

   // Monitor: checks handshake expectations and pops the scoreboard on every consume
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (chk_en && !reset) begin
            chk("instrValid", 32'(instrValid), 32'(!redirectValid && exp_q.size() != 0));
            chk("fetchReady", 32'(fetchReady), 32'(!redirectValid && pend <= 1));
            chk("fetchAddr", fetchAddr, m_fa);
            if (prev_hold) begin
               chk("hold_word", instrWord, prev_word);
               chk("hold_pc", instrPc, prev_pc);
            end
            if (instrValid && instrReady) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_instr: got %h at pc %h expected none", instrWord, instrPc);
               end else begin
                  e = exp_q.pop_front();
                  chk("instrWord", instrWord, e.w);
                  chk("instrPc", instrPc, e.pc);
                  chk("instrIsCompressed", 32'(instrIsCompressed), 32'(e.c));
                  pend = pend - (e.c ? 1 : 2);
               end
            end
            prev_hold = instrValid && !instrReady && !redirectValid;
            prev_word = instrWord;
            prev_pc   = instrPc;
         end else begin
            prev_hold = 1'b0;
         end
      end
   end

   initial begin
      logic [15:0] h0, h1;
      reset         = 1'b1;
      fetchValid    = 1'b0;
      fetchWord     = '0;
      redirectValid = 1'b0;
      redirectPc    = '0;
      instrReady    = 1'b0;
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[0]  = 32'h0000_0013;
      mem[1]  = 32'h9532_9532;
      mem[2]  = 32'h0013_9532;
      mem[3]  = 32'h9532_0000;
      mem[6]  = 32'h0073_1234;
      mem[7]  = 32'h00B3_9532;
      mem[63] = 32'h0013_0513;
      mem[64'h40 >> 0 & 63] = 32'h9532_0013;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_instrValid", 32'(instrValid), 32'd0);
      chk("rst_fetchReady", 32'(fetchReady), 32'd1);
      chk("rst_instrWord", instrWord, 32'd0);
      chk("rst_instrPc", instrPc, RESET_PC);
      chk("rst_isCompressed", 32'(instrIsCompressed), 32'd0);
      chk("rst_fetchAddr", fetchAddr, {RESET_PC[31:2], 2'b00});
      m_restart(RESET_PC);
      reset  = 1'b0;
      chk_en = 1'b1;

      // Straight-line stream from reset, covering c.add pairs and the straddle
      repeat (10) step(1, 1, 0, 0);

      // Backpressure with a full buffer, then release
      step(0, 0, 1, 32'h0000_0004);
      repeat (7) step(1, 0, 0, 0);
      repeat (6) step(1, 1, 0, 0);

      // Redirect into the upper half of a word
      mem[32'h100 >> 2 & 63] = 32'h9532_0013;
      step(0, 1, 1, 32'h0000_0102);
      repeat (3) step(1, 1, 0, 0);

      // Redirect coincident with a fetch and a consume
      step(1, 1, 0, 0);
      step(1, 1, 1, 32'h0000_0018);
      repeat (4) step(1, 1, 0, 0);

      // Asynchronous reset while a 32-bit instruction is only half buffered
      step(0, 0, 1, 32'h0000_0008);
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      @(negedge clk);
      fetchValid = 1'b0;
      instrReady = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      chk("midrst_instrValid", 32'(instrValid), 32'd0);
      chk("midrst_fetchAddr", fetchAddr, {RESET_PC[31:2], 2'b00});
      m_restart(RESET_PC);
      prev_hold = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (4) step(1, 1, 0, 0);

      // Address wrap past the top of memory
      step(0, 1, 1, 32'hFFFF_FFFA);
      repeat (6) step(1, 1, 0, 0);

      // Randomized program with random handshakes and redirects
      for (int i = 0; i < 64; i++) begin
         h0 = 16'($urandom);
         h1 = 16'($urandom);
         if ($urandom_range(1) == 1) h0[1:0] = 2'b11; else h0[1:0] = 2'($urandom_range(2));
         if ($urandom_range(1) == 1) h1[1:0] = 2'b11; else h1[1:0] = 2'($urandom_range(2));
         if ($urandom_range(15) == 0) h0 = 16'h0000;
         mem[i] = {h1, h0};
      end
      step(0, 1, 1, $urandom & 32'hFFFF_FFFE);
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(99) < 75, $urandom_range(99) < 70,
              $urandom_range(99) < 3, $urandom & 32'hFFFF_FFFE);
      end

      // Drain whatever complete instructions remain
      repeat (8) step(0, 1, 0, 0);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
